// File: rtl/wave_sweep_sched.sv
// wave_sweep_sched: once per frame, reads N_POINTS samples from the capture
// buffer, maps each sample to a screen row, and streams (x, y, oor) points to
// the wave-plot renderer through a 2-entry skid FIFO under ready/valid.
module wave_sweep_sched #(
  parameter int N_POINTS = 500,
  parameter int Y_TOP    = 100,
  parameter int Y_SHIFT  = 4
) (
  input  logic        lcd_clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        wave_run,
  output logic        wave_data_req,
  output logic [9:0]  wave_rd_addr,
  input  logic [11:0] wave_rd_data,
  input  logic        outrange,
  output logic        pt_valid,
  input  logic        pt_ready,
  output logic [9:0]  pt_x,
  output logic [9:0]  pt_y,
  output logic        pt_oor,
  output logic        lcd_wr_over,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_r, state_nx_s;
  logic [9:0]  cnt_r;          // next address to issue
  logic [9:0]  last_addr_r;    // last issued address, shown while idle
  logic        inflight_r;     // a read was issued last cycle
  logic [9:0]  inflight_x_r;   // address of that read, becomes the point x
  logic [1:0]  count_r;        // FIFO occupancy
  logic [9:0]  e1_x_r, e1_y_r;
  logic        e1_oor_r;
  logic        issue_s, push_s, pop_s;
  logic [1:0]  occ_s, count_nx_s;
  logic [9:0]  new_y_s;

  // wave_run only gates re-arm on the capture side; sweeps ignore it.
  logic unused_wave_run;
  assign unused_wave_run = wave_run;

  // Map a 12-bit sample to a screen row; large codes sit near the top.
  function automatic logic [9:0] map_y(input logic [11:0] d);
    logic [11:0] inv;
    logic [11:0] sh;
    logic [12:0] sum;
    inv = 12'd4095 - d;
    sh  = inv >> Y_SHIFT;
    sum = 13'(Y_TOP) + {1'b0, sh};
    if (sum > 13'd1023) begin
      map_y = 10'd1023;
    end else begin
      map_y = sum[9:0];
    end
  endfunction

  // Issue decision. The slot freed by a same-cycle pop counts as free, which
  // is what sustains one point per cycle, so the request is combinational.
  always_comb begin
    pop_s   = pt_valid & pt_ready;
    push_s  = inflight_r;
    occ_s   = count_r + {1'b0, inflight_r} - {1'b0, pop_s};
    issue_s = 1'b0;
    if (state_r == S_SWEEP && occ_s < 2'd2) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    count_nx_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
    new_y_s    = map_y(wave_rd_data);
  end

  assign wave_data_req = issue_s;
  assign wave_rd_addr  = issue_s ? cnt_r : last_addr_r;

  // Next-state logic for the sweep sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (frame_start) state_nx_s = S_SWEEP;
        else             state_nx_s = S_IDLE;
      end
      S_SWEEP: begin
        if (issue_s && cnt_r == 10'(N_POINTS - 1)) state_nx_s = S_DRAIN;
        else                                       state_nx_s = S_SWEEP;
      end
      S_DRAIN: begin
        if (count_nx_s == 2'd0 && !inflight_r) state_nx_s = S_DONE;
        else                                   state_nx_s = S_DRAIN;
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Sequencer state, address counter and status flags.
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= 10'd0;
      last_addr_r <= 10'd0;
      lcd_wr_over <= 1'b1;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (state_r == S_IDLE && frame_start) begin
        cnt_r       <= 10'd0;
        lcd_wr_over <= 1'b0;
        busy        <= 1'b1;
      end
      if (issue_s) begin
        cnt_r       <= cnt_r + 10'd1;
        last_addr_r <= cnt_r;
      end
      if (state_r == S_DRAIN && state_nx_s == S_DONE) begin
        lcd_wr_over <= 1'b1;
        busy        <= 1'b0;
      end
      if (frame_start && (state_r == S_SWEEP || state_r == S_DRAIN)) begin
        overrun <= 1'b1;
      end
    end
  end

  // Carry the issued address alongside the read until its data returns.
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r   <= 1'b0;
      inflight_x_r <= 10'd0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) inflight_x_r <= cnt_r;
    end
  end

  // 2-entry point FIFO; entry 0 is the head and drives pt_* directly.
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= 2'd0;
      pt_valid <= 1'b0;
      pt_x     <= 10'd0;
      pt_y     <= 10'd0;
      pt_oor   <= 1'b0;
      e1_x_r   <= 10'd0;
      e1_y_r   <= 10'd0;
      e1_oor_r <= 1'b0;
    end else begin
      count_r  <= count_nx_s;
      pt_valid <= (count_nx_s != 2'd0);
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            pt_x <= inflight_x_r; pt_y <= new_y_s; pt_oor <= outrange;
          end else begin
            e1_x_r <= inflight_x_r; e1_y_r <= new_y_s; e1_oor_r <= outrange;
          end
        end
        2'b01: begin
          pt_x <= e1_x_r; pt_y <= e1_y_r; pt_oor <= e1_oor_r;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            pt_x <= inflight_x_r; pt_y <= new_y_s; pt_oor <= outrange;
          end else begin
            pt_x   <= e1_x_r;       pt_y   <= e1_y_r;  pt_oor   <= e1_oor_r;
            e1_x_r <= inflight_x_r; e1_y_r <= new_y_s; e1_oor_r <= outrange;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_sweep_sched.sv
// Scoreboard bench for wave_sweep_sched: expected points are queued when a
// sweep is started; negedge monitors pop and compare on each accepted point.
module tb_wave_sweep_sched;
  localparam int N = 500;

  logic        lcd_clk = 1'b0;
  logic        rst_n = 1'b0, frame_start = 1'b0, wave_run = 1'b1;
  logic        pt_ready = 1'b0, outrange = 1'b0;
  logic [11:0] wave_rd_data = 12'd0;
  logic        wave_data_req, pt_valid, pt_oor, lcd_wr_over, busy, overrun;
  logic [9:0]  wave_rd_addr, pt_x, pt_y;

  // second instance: short sweep, no shift, exercises saturation
  logic        frame_start2 = 1'b0, outrange2 = 1'b0;
  logic [11:0] rd_data2 = 12'd0;
  logic        req2, valid2, oor2, wr_over2, busy2, overrun2;
  logic [9:0]  addr2, x2, y2;

  wave_sweep_sched #(.N_POINTS(N), .Y_TOP(100), .Y_SHIFT(4)) u_dut (
    .lcd_clk(lcd_clk), .rst_n(rst_n), .frame_start(frame_start), .wave_run(wave_run),
    .wave_data_req(wave_data_req), .wave_rd_addr(wave_rd_addr), .wave_rd_data(wave_rd_data),
    .outrange(outrange), .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y),
    .pt_oor(pt_oor), .lcd_wr_over(lcd_wr_over), .busy(busy), .overrun(overrun));

  wave_sweep_sched #(.N_POINTS(4), .Y_TOP(100), .Y_SHIFT(0)) u_dut2 (
    .lcd_clk(lcd_clk), .rst_n(rst_n), .frame_start(frame_start2), .wave_run(1'b1),
    .wave_data_req(req2), .wave_rd_addr(addr2), .wave_rd_data(rd_data2),
    .outrange(outrange2), .pt_valid(valid2), .pt_ready(1'b1), .pt_x(x2), .pt_y(y2),
    .pt_oor(oor2), .lcd_wr_over(wr_over2), .busy(busy2), .overrun(overrun2));

  always #5 lcd_clk = ~lcd_clk;

  int cyc = 0;
  always @(posedge lcd_clk) cyc <= cyc + 1;

  int n_pass = 0, n_total = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { int x; int y; int oor; } pt_t;
  pt_t exp_q[$];
  pt_t exp_q2[$];

  function automatic int exp_y(input int d, input int top, input int sh);
    int v;
    v = top + ((4095 - d) >> sh);
    return (v > 1023) ? 1023 : v;
  endfunction

  // capture-buffer models: one-cycle read latency
  int oor_lim = 0;
  always @(posedge lcd_clk) begin
    if (wave_data_req) begin
      wave_rd_data <= 12'(int'(wave_rd_addr) * 8);
      outrange     <= (int'(wave_rd_addr) < oor_lim);
    end
  end
  always @(posedge lcd_clk) begin
    if (req2) begin
      case (addr2)
        10'd0:   rd_data2 <= 12'd0;
        10'd1:   rd_data2 <= 12'd4095;
        10'd2:   rd_data2 <= 12'd2048;
        default: rd_data2 <= 12'd4000;
      endcase
    end
  end

  // monitor state
  int   fs_cyc = 0;
  int   rise_cyc = 0;
  int   n_pop = 0;
  int   occ = 0;
  logic stall_r = 1'b0, prev_wo = 1'b1;
  logic [9:0] px = 10'd0, py = 10'd0;
  logic pox = 1'b0;

  // main monitor: scoreboard compare, stall stability, occupancy, timing
  always @(negedge lcd_clk) begin
    if (!rst_n) begin
      occ <= 0; stall_r <= 1'b0; prev_wo <= 1'b1;
    end else begin
      if (wave_data_req) begin
        chk("req_room", int'(occ - int'(pt_valid && pt_ready) < 2), 1);
        if (wave_rd_addr == 10'd0) chk("first_req_lat", cyc + 1 - fs_cyc, 1);
      end
      occ <= occ + int'(wave_data_req) - int'(pt_valid && pt_ready);
      if (stall_r) begin
        chk("stall_valid", int'(pt_valid), 1);
        chk("stall_x", int'(pt_x), int'(px));
        chk("stall_y", int'(pt_y), int'(py));
        chk("stall_oor", int'(pt_oor), int'(pox));
      end
      stall_r <= pt_valid && !pt_ready;
      px <= pt_x; py <= pt_y; pox <= pt_oor;
      if (pt_valid && pt_ready) begin
        n_pop <= n_pop + 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_point_x", int'(pt_x), -1);
        end else begin
          pt_t e;
          e = exp_q.pop_front();
          chk("pt_x", int'(pt_x), e.x);
          chk("pt_y", int'(pt_y), e.y);
          chk("pt_oor", int'(pt_oor), e.oor);
        end
        if (pt_x == 10'd0)   chk("y_at_x0", int'(pt_y), 355);
        if (pt_x == 10'd499) chk("y_at_x499", int'(pt_y), 106);
      end
      if (lcd_wr_over && !prev_wo) rise_cyc <= cyc + 1;
      prev_wo <= lcd_wr_over;
    end
  end

  // monitor for the saturation instance
  always @(negedge lcd_clk) begin
    if (rst_n && valid2) begin
      if (exp_q2.size() == 0) begin
        chk("unexpected_point2_x", int'(x2), -1);
      end else begin
        pt_t e;
        e = exp_q2.pop_front();
        chk("pt2_x", int'(x2), e.x);
        chk("pt2_y", int'(y2), e.y);
      end
    end
  end

  task automatic push_sweep(input int lim);
    for (int x = 0; x < N; x++) exp_q.push_back('{x, exp_y(x * 8, 100, 4), int'(x < lim)});
  endtask

  task automatic start_sweep();
    @(posedge lcd_clk); #1;
    frame_start = 1'b1;
    fs_cyc = cyc + 1;
    @(posedge lcd_clk); #1;
    frame_start = 1'b0;
  endtask

  // run until lcd_wr_over rises; rnd selects a ~30% duty pt_ready
  task automatic wait_done(input bit rnd, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (rnd) pt_ready = ($urandom_range(99) < 30);
      @(posedge lcd_clk); #1;
      if (lcd_wr_over) begin ok = 1'b1; break; end
    end
    chk({name, "_completed"}, int'(ok), 1);
    pt_ready = 1'b1;
    @(negedge lcd_clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, int'(wave_data_req), 0);
    chk({tag, "_addr"}, int'(wave_rd_addr), 0);
    chk({tag, "_valid"}, int'(pt_valid), 0);
    chk({tag, "_x"}, int'(pt_x), 0);
    chk({tag, "_y"}, int'(pt_y), 0);
    chk({tag, "_oor"}, int'(pt_oor), 0);
    chk({tag, "_wr_over"}, int'(lcd_wr_over), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    int p0;
    int nreq;
    repeat (3) @(posedge lcd_clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // 1: full sweep, ready held high
    pt_ready = 1'b1;
    push_sweep(0);
    p0 = n_pop;
    start_sweep();
    chk("busy_during_sweep", int'(busy), 1);
    chk("wr_over_low_in_sweep", int'(lcd_wr_over), 0);
    wait_done(1'b0, "sweep1");
    chk("sweep1_len", rise_cyc - fs_cyc, 503);
    chk("sweep1_points", n_pop - p0, N);
    chk("sweep1_q_empty", exp_q.size(), 0);
    chk("sweep1_busy", int'(busy), 0);
    chk("sweep1_overrun", int'(overrun), 0);

    // 2: random back-pressure, outrange on 0..9, acquisition stopped
    wave_run = 1'b0;
    oor_lim = 10;
    push_sweep(10);
    p0 = n_pop;
    start_sweep();
    wait_done(1'b1, "sweep2");
    chk("sweep2_points", n_pop - p0, N);
    chk("sweep2_q_empty", exp_q.size(), 0);
    oor_lim = 0;
    wave_run = 1'b1;

    // 3: second frame_start mid-sweep
    push_sweep(0);
    p0 = n_pop;
    start_sweep();
    repeat (198) @(posedge lcd_clk);
    #1;
    frame_start = 1'b1;
    @(posedge lcd_clk); #1;
    frame_start = 1'b0;
    chk("overrun_set", int'(overrun), 1);
    wait_done(1'b0, "sweep3");
    chk("sweep3_points", n_pop - p0, N);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge lcd_clk); #1;
      nreq += int'(wave_data_req) + int'(busy);
    end
    chk("no_restart", nreq, 0);
    chk("overrun_sticky", int'(overrun), 1);
    chk("sweep3_q_empty", exp_q.size(), 0);

    // 4: reset at point 250, then a clean sweep
    push_sweep(0);
    p0 = n_pop;
    start_sweep();
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(posedge lcd_clk); #1;
        if (n_pop - p0 >= 250) begin ok = 1'b1; break; end
      end
      chk("reach_point_250", int'(ok), 1);
    end
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    exp_q.delete();
    repeat (2) @(posedge lcd_clk);
    #1;
    rst_n = 1'b1;
    push_sweep(0);
    p0 = n_pop;
    start_sweep();
    wait_done(1'b1, "sweep5");
    chk("sweep5_points", n_pop - p0, N);
    chk("sweep5_q_empty", exp_q.size(), 0);

    // 6: saturation instance (Y_SHIFT=0): data 0,4095,2048,4000
    exp_q2.push_back('{0, 1023, 0});
    exp_q2.push_back('{1, 100, 0});
    exp_q2.push_back('{2, 1023, 0});
    exp_q2.push_back('{3, 195, 0});
    @(posedge lcd_clk); #1;
    frame_start2 = 1'b1;
    @(posedge lcd_clk); #1;
    frame_start2 = 1'b0;
    repeat (20) @(posedge lcd_clk);
    #1;
    chk("sat_q_empty", exp_q2.size(), 0);
    chk("sat_wr_over", int'(wr_over2), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
